// File: rtl/pipe_pkg.sv
// Shared MEM->WB definitions: WB control bit positions, default widths and payload layout.
package pipe_pkg;

  localparam int unsigned WB_REG_WRITE  = 0;
  localparam int unsigned WB_MEM_TO_REG = 1;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_REG_W  = 5;
  localparam int unsigned DEF_CTRL_W = 2;

  typedef struct packed {
    logic [DEF_CTRL_W-1:0] ctrl;
    logic [DEF_DATA_W-1:0] read_data;
    logic [DEF_DATA_W-1:0] alu_result;
    logic [DEF_REG_W-1:0]  wr_reg;
  } mem_wb_payload_t;

  localparam int unsigned DEF_PAYLOAD_W = $bits(mem_wb_payload_t);

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid flag plus payload; clear beats load, payload changes only on load.
module pipe_slot #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register with valid/ready handshake, flush and optional 2-entry skid buffer.
module mem_wb_pipe_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned REG_W  = DEF_REG_W,
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter bit          SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_wb_in,
  input  logic [DATA_W-1:0] read_data_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [REG_W-1:0]  write_reg_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] mem_ctrl_wb,
  output logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [REG_W-1:0]  mem_write_reg
);

  localparam int unsigned PW = CTRL_W + 2 * DATA_W + REG_W;

  logic          out_v, skid_v;
  logic [PW-1:0] in_pl, out_pl, skid_pl, out_src;
  logic          in_fire, out_room;
  logic          out_load, out_clear, skid_load, skid_clear;

  assign in_pl = {ctrl_wb_in, read_data_in, alu_result_in, write_reg_in};

  // Slot control: output refills from skid first, else from the input; flush wins over loads.
  always_comb begin
    in_fire    = in_valid & in_ready;
    out_room   = ~out_v | out_ready;
    out_load   = ~flush & out_room & (skid_v | in_fire);
    out_clear  = flush | (out_v & out_ready & ~skid_v & ~in_fire);
    skid_load  = ~flush & in_fire & out_v & ~out_ready;
    skid_clear = flush | (skid_v & out_ready);
    out_src    = skid_v ? skid_pl : in_pl;
  end

  pipe_slot #(.W(PW)) u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (out_load),
    .clear_i (out_clear),
    .data_i  (out_src),
    .valid_o (out_v),
    .data_o  (out_pl)
  );

  generate
    if (SKID) begin : g_skid
      pipe_slot #(.W(PW)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .data_i  (in_pl),
        .valid_o (skid_v),
        .data_o  (skid_pl)
      );
      // Registered ready: no combinational path from out_ready.
      assign in_ready = ~skid_v;
    end else begin : g_noskid
      assign skid_v   = 1'b0;
      assign skid_pl  = '0;
      assign in_ready = ~out_v | out_ready;
    end
  endgenerate

  assign out_valid      = out_v;
  assign mem_ctrl_wb    = out_v ? out_pl[PW-1 -: CTRL_W] : CTRL_W'(0);
  assign read_data      = out_pl[PW-CTRL_W-1 -: DATA_W];
  assign mem_alu_result = out_pl[REG_W +: DATA_W];
  assign mem_write_reg  = out_pl[REG_W-1:0];

endmodule
